// File: rtl/regfile_scoreboard_if.sv
// Register-file bus: writeback, two read ports, reservation and pending bits.
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 19,
    parameter int NUM_REGS   = 8
);
    localparam int AW = $clog2(NUM_REGS);

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd0_en;
    logic [AW-1:0]         rd0_addr;
    logic [DATA_WIDTH-1:0] rd0_data;
    logic                  rd0_valid;
    logic                  rd1_en;
    logic [AW-1:0]         rd1_addr;
    logic [DATA_WIDTH-1:0] rd1_data;
    logic                  rd1_valid;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;
    logic                  rsv_ack;
    logic [NUM_REGS-1:0]   busy;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd0_en, rd0_addr, rd1_en, rd1_addr,
        output rsv_en, rsv_addr,
        input  rd0_data, rd0_valid, rd1_data, rd1_valid, rsv_ack, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd0_en, rd0_addr, rd1_en, rd1_addr,
        input  rsv_en, rsv_addr,
        output rd0_data, rd0_valid, rd1_data, rd1_valid, rsv_ack, busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with one write port, two registered read ports, write-to-read
// forwarding, per-register pending bits and an optional hardwired zero register.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 19,
    parameter int NUM_REGS   = 8,
    parameter bit ZERO_REG   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    regfile_scoreboard_if.slave bus
);
    localparam int AW  = $clog2(NUM_REGS);
    localparam int NRD = 2;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]                 busy;
    logic                                rsv_ack;
    logic [NRD-1:0]                      rd_en;
    logic [NRD-1:0][AW-1:0]              rd_addr;
    logic [NRD-1:0][DATA_WIDTH-1:0]      rd_data;
    logic [NRD-1:0]                      rd_valid;
    logic                                wr_eff;
    logic                                rsv_zero;
    logic                                rsv_pend;

    assign rd_en   = {bus.rd1_en, bus.rd0_en};
    assign rd_addr = {bus.rd1_addr, bus.rd0_addr};

    assign bus.rd0_data  = rd_data[0];
    assign bus.rd1_data  = rd_data[1];
    assign bus.rd0_valid = rd_valid[0];
    assign bus.rd1_valid = rd_valid[1];
    assign bus.rsv_ack   = rsv_ack;
    assign bus.busy      = busy;

    // A write to the hardwired zero register is dropped before storage and forwarding.
    assign wr_eff   = bus.wr_en && !(ZERO_REG && bus.wr_addr == '0);
    assign rsv_zero = ZERO_REG && bus.rsv_addr == '0;
    // Pending state as seen after this cycle's writeback retires.
    assign rsv_pend = busy[bus.rsv_addr] && !(wr_eff && bus.wr_addr == bus.rsv_addr);

    // Register storage: single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         regs <= '0;
        else if (wr_eff) regs[bus.wr_addr] <= bus.wr_data;
    end

    // Scoreboard: writeback clears, an accepted reservation sets (set wins on same reg).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= '0;
            rsv_ack <= 1'b0;
        end else begin
            if (wr_eff) busy[bus.wr_addr] <= 1'b0;
            if (bus.rsv_en && !rsv_pend && !rsv_zero) busy[bus.rsv_addr] <= 1'b1;
            rsv_ack <= bus.rsv_en && !rsv_pend;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic                  fwd;
        logic                  zero;
        logic [DATA_WIDTH-1:0] q;
        logic                  v;

        assign fwd  = wr_eff && bus.wr_addr == rd_addr[p];
        assign zero = ZERO_REG && rd_addr[p] == '0;
        assign rd_data[p]  = q;
        assign rd_valid[p] = v;

        // Read port: sampled against pre-reservation busy, with same-cycle forwarding.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= '0;
                v <= 1'b0;
            end else begin
                v <= rd_en[p] && (zero || fwd || !busy[rd_addr[p]]);
                if (rd_en[p]) q <= zero ? '0 : (fwd ? bus.wr_data : regs[rd_addr[p]]);
            end
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default build plus a ZERO_REG=1 build.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.DATA_WIDTH(19), .NUM_REGS(8)) ifa ();
    regfile_scoreboard_if #(.DATA_WIDTH(19), .NUM_REGS(8)) ifz ();

    regfile_scoreboard #(.DATA_WIDTH(19), .NUM_REGS(8), .ZERO_REG(1'b0)) dut (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    regfile_scoreboard #(.DATA_WIDTH(19), .NUM_REGS(8), .ZERO_REG(1'b1)) dutz (
        .clk(clk), .rst(rst), .bus(ifz.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_a();
        ifa.wr_en = 0; ifa.wr_addr = 0; ifa.wr_data = 0;
        ifa.rd0_en = 0; ifa.rd0_addr = 0; ifa.rd1_en = 0; ifa.rd1_addr = 0;
        ifa.rsv_en = 0; ifa.rsv_addr = 0;
    endtask

    task automatic clr_z();
        ifz.wr_en = 0; ifz.wr_addr = 0; ifz.wr_data = 0;
        ifz.rd0_en = 0; ifz.rd0_addr = 0; ifz.rd1_en = 0; ifz.rd1_addr = 0;
        ifz.rsv_en = 0; ifz.rsv_addr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_a();
        clr_z();
        #2;
        check("rst_busy", 32'(ifa.busy), 32'h0);
        check("rst_rd0_data", 32'(ifa.rd0_data), 32'h0);
        check("rst_rd0_valid", 32'(ifa.rd0_valid), 32'h0);
        check("rst_rsv_ack", 32'(ifa.rsv_ack), 32'h0);
        tick(); tick();
        #2 rst = 1'b0;

        // writes r1, r2, r7
        ifa.wr_en = 1; ifa.wr_addr = 1; ifa.wr_data = 19'h5AAAA; tick();
        ifa.wr_addr = 2; ifa.wr_data = 19'h7FFFF; tick();
        ifa.wr_addr = 7; ifa.wr_data = 19'h00001; tick();
        clr_a();
        ifa.rd0_en = 1; ifa.rd0_addr = 1; ifa.rd1_en = 1; ifa.rd1_addr = 2; tick();
        check("rd_r1_data", 32'(ifa.rd0_data), 32'h5AAAA);
        check("rd_r1_valid", 32'(ifa.rd0_valid), 32'h1);
        check("rd_r2_data", 32'(ifa.rd1_data), 32'h7FFFF);
        check("rd_r2_valid", 32'(ifa.rd1_valid), 32'h1);
        ifa.rd0_addr = 7; ifa.rd1_en = 0; tick();
        check("rd_r7_data", 32'(ifa.rd0_data), 32'h00001);
        check("rd1_idle_valid", 32'(ifa.rd1_valid), 32'h0);
        check("rd1_idle_hold", 32'(ifa.rd1_data), 32'h7FFFF);

        // same-cycle forwarding on both ports
        clr_a();
        ifa.wr_en = 1; ifa.wr_addr = 3; ifa.wr_data = 19'h12345;
        ifa.rd0_en = 1; ifa.rd0_addr = 3; ifa.rd1_en = 1; ifa.rd1_addr = 3; tick();
        check("fwd_rd0_data", 32'(ifa.rd0_data), 32'h12345);
        check("fwd_rd0_valid", 32'(ifa.rd0_valid), 32'h1);
        check("fwd_rd1_data", 32'(ifa.rd1_data), 32'h12345);
        check("fwd_rd1_valid", 32'(ifa.rd1_valid), 32'h1);
        clr_a();
        ifa.rd0_en = 1; ifa.rd0_addr = 3; tick();
        check("r3_later_data", 32'(ifa.rd0_data), 32'h12345);

        // scoreboard on r4
        clr_a();
        ifa.rsv_en = 1; ifa.rsv_addr = 4; tick();
        check("rsv_r4_ack", 32'(ifa.rsv_ack), 32'h1);
        check("rsv_r4_busy", 32'(ifa.busy), 32'h10);
        clr_a();
        ifa.rd0_en = 1; ifa.rd0_addr = 4; tick();
        check("pend_r4_valid", 32'(ifa.rd0_valid), 32'h0);
        check("pend_r4_data", 32'(ifa.rd0_data), 32'h0);
        clr_a();
        ifa.rsv_en = 1; ifa.rsv_addr = 4; tick();
        check("rersv_r4_ack", 32'(ifa.rsv_ack), 32'h0);
        check("rersv_r4_busy", 32'(ifa.busy), 32'h10);
        clr_a();
        ifa.wr_en = 1; ifa.wr_addr = 4; ifa.wr_data = 19'h30003; tick();
        check("wb_r4_busy", 32'(ifa.busy), 32'h0);
        check("wb_r4_ack_idle", 32'(ifa.rsv_ack), 32'h0);
        clr_a();
        ifa.rd0_en = 1; ifa.rd0_addr = 4; tick();
        check("rd_r4_data", 32'(ifa.rd0_data), 32'h30003);
        check("rd_r4_valid", 32'(ifa.rd0_valid), 32'h1);
        clr_a(); tick();
        check("rd0_idle_valid", 32'(ifa.rd0_valid), 32'h0);
        check("rd0_idle_hold", 32'(ifa.rd0_data), 32'h30003);

        // write + reserve + read on pending r5 in one cycle
        ifa.rsv_en = 1; ifa.rsv_addr = 5; tick();
        check("rsv_r5_busy", 32'(ifa.busy), 32'h20);
        clr_a();
        ifa.wr_en = 1; ifa.wr_addr = 5; ifa.wr_data = 19'h000FF;
        ifa.rsv_en = 1; ifa.rsv_addr = 5;
        ifa.rd0_en = 1; ifa.rd0_addr = 5; tick();
        check("sim_r5_ack", 32'(ifa.rsv_ack), 32'h1);
        check("sim_r5_busy", 32'(ifa.busy), 32'h20);
        check("sim_r5_data", 32'(ifa.rd0_data), 32'h000FF);
        check("sim_r5_valid", 32'(ifa.rd0_valid), 32'h1);

        // reservation does not affect same-cycle read
        clr_a();
        ifa.rsv_en = 1; ifa.rsv_addr = 6; ifa.rd1_en = 1; ifa.rd1_addr = 6; tick();
        check("ord_r6_valid", 32'(ifa.rd1_valid), 32'h1);
        check("ord_r6_ack", 32'(ifa.rsv_ack), 32'h1);
        check("ord_r6_busy", 32'(ifa.busy), 32'h60);

        // asynchronous reset between edges
        clr_a();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(ifa.busy), 32'h0);
        check("arst_rd0_data", 32'(ifa.rd0_data), 32'h0);
        check("arst_rd1_valid", 32'(ifa.rd1_valid), 32'h0);
        check("arst_rsv_ack", 32'(ifa.rsv_ack), 32'h0);
        #1 rst = 1'b0;
        ifa.rd0_en = 1; ifa.rd0_addr = 1; tick();
        check("post_rst_r1_data", 32'(ifa.rd0_data), 32'h0);
        check("post_rst_r1_valid", 32'(ifa.rd0_valid), 32'h1);
        clr_a();

        // ZERO_REG build
        ifz.wr_en = 1; ifz.wr_addr = 0; ifz.wr_data = 19'h7FFFF; tick();
        clr_z();
        ifz.rd0_en = 1; ifz.rd0_addr = 0; tick();
        check("z_r0_data", 32'(ifz.rd0_data), 32'h0);
        check("z_r0_valid", 32'(ifz.rd0_valid), 32'h1);
        clr_z();
        ifz.wr_en = 1; ifz.wr_addr = 0; ifz.wr_data = 19'h12345;
        ifz.rd1_en = 1; ifz.rd1_addr = 0; tick();
        check("z_r0_nofwd", 32'(ifz.rd1_data), 32'h0);
        clr_z();
        ifz.rsv_en = 1; ifz.rsv_addr = 0; tick();
        check("z_rsv_r0_ack", 32'(ifz.rsv_ack), 32'h1);
        check("z_rsv_r0_busy", 32'(ifz.busy), 32'h0);
        clr_z();
        ifz.wr_en = 1; ifz.wr_addr = 1; ifz.wr_data = 19'h5AAAA;
        ifz.rsv_en = 1; ifz.rsv_addr = 2; tick();
        check("z_rsv_r2_busy", 32'(ifz.busy), 32'h04);
        clr_z();
        ifz.rd0_en = 1; ifz.rd0_addr = 1; tick();
        check("z_r1_data", 32'(ifz.rd0_data), 32'h5AAAA);
        clr_z();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
